// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instROM address/data, instruction slot handshake to decode, branch redirect and halt status.
// master = fetch_unit side, slave = ROM/decoder/testbench side.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 8
);
  logic              start_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic              branch_i;
  logic              branch_rel_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              halted_o;

  modport master (
    input  start_i, rom_data_i, inst_ready_i, branch_i, branch_rel_i, branch_target_i,
    output rom_addr_o, inst_o, inst_pc_o, inst_valid_o, halted_o
  );

  modport slave (
    output start_i, rom_data_i, inst_ready_i, branch_i, branch_rel_i, branch_target_i,
    input  rom_addr_o, inst_o, inst_pc_o, inst_valid_o, halted_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC drives instROM, one-slot registered output (1-cycle latency) held while decoder stalls.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                INST_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [INST_W-1:0] HALT_OPCODE = '1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  fetch_unit_if.master bus
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [INST_W-1:0] r_inst, w_inst_nxt;
  logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
  logic              r_valid, w_valid_nxt;

  logic              w_load;
  logic              w_halt;
  logic [ADDR_W-1:0] w_target;

  assign w_load   = (r_state == S_FETCH) && (!r_valid || bus.inst_ready_i) && !bus.branch_i;
  assign w_halt   = HALT_EN && w_load && (bus.rom_data_i == HALT_OPCODE);
  // Relative offset is two's complement, so a plain modular add gives the signed result.
  assign w_target = bus.branch_rel_i ? ADDR_W'(r_inst_pc + bus.branch_target_i)
                                     : bus.branch_target_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_valid_nxt   = r_valid;

    if (r_valid && bus.inst_ready_i) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.branch_i) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
        end else if (w_load) begin
          w_inst_nxt    = bus.rom_data_i;
          w_inst_pc_nxt = r_pc;
          w_valid_nxt   = 1'b1;
          if (w_halt) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = ADDR_W'(r_pc + ADDR_W'(1));
          end
        end
      end
      S_HALT: begin
        if (bus.start_i) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign bus.rom_addr_o   = r_pc;
  assign bus.inst_o       = r_inst;
  assign bus.inst_pc_o    = r_inst_pc;
  assign bus.inst_valid_o = r_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted_o = (r_state == S_HALT);
`else
  assign bus.halted_o = 1'b0;
`endif

endmodule
